// File: rtl/country_car_sensor.sv
// Country-road car sensor: synchronizes and debounces loop detectors, keeps a saturating queue count, and drives request x.
// Optional stuck-arrival detection is built only when STUCK_DETECT_EN is defined.
module country_car_sensor #(
   parameter int DB_CYCLES    = 4,
   parameter int CNT_W        = 4,
   parameter int STUCK_CYCLES = 1024
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             car_arr_raw,
   input  logic             car_dep_raw,
   input  logic [1:0]       cntry,
   output logic             x,
   output logic [CNT_W-1:0] queue_cnt,
   output logic             q_ovf,
   output logic             sensor_fault
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [7:0]       DB_LAST = 8'(DB_CYCLES - 1);

   logic             arr_s1, arr_s2, dep_s1, dep_s2;
   logic             arr_deb, dep_deb, arr_deb_d, dep_deb_d;
   logic [7:0]       arr_db_cnt, dep_db_cnt;
   logic [8:0]       arr_db_nxt, dep_db_nxt;
   logic             arr_p0, dep_p0, dep_ok;
   logic [CNT_W-1:0] cnt_nxt;
   logic             ovf_hit;
   logic             fault_nxt;

   // A level change is accepted on the DB_CYCLES-th consecutive mismatching edge.
   function automatic logic [8:0] db_step(input logic s2, input logic deb, input logic [7:0] cnt);
      if (s2 == deb)
         return {deb, 8'd0};
      else if (cnt == DB_LAST)
         return {s2, 8'd0};
      else
         return {deb, cnt + 8'd1};
   endfunction

   // Saturating queue step; returns {overflow_hit, next_count}.
   function automatic logic [CNT_W:0] queue_step(input logic [CNT_W-1:0] cnt, input logic inc,
                                                 input logic dec);
      logic [CNT_W-1:0] n;
      logic             o;
      n = cnt;
      o = 1'b0;
      case ({inc, dec})
         2'b10: begin
            if (cnt == CNT_MAX) o = 1'b1;
            else                n = cnt + 1'b1;
         end
         2'b01: if (cnt != '0) n = cnt - 1'b1;
         default: ;
      endcase
      return {o, n};
   endfunction

   // Stage: two-flop synchronizers
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         arr_s1 <= 1'b0;
         arr_s2 <= 1'b0;
         dep_s1 <= 1'b0;
         dep_s2 <= 1'b0;
      end else begin
         arr_s1 <= car_arr_raw;
         arr_s2 <= arr_s1;
         dep_s1 <= car_dep_raw;
         dep_s2 <= dep_s1;
      end
   end

   // Stage: debounce and edge history
   always_comb begin
      arr_db_nxt = db_step(arr_s2, arr_deb, arr_db_cnt);
      dep_db_nxt = db_step(dep_s2, dep_deb, dep_db_cnt);
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         arr_deb    <= 1'b0;
         dep_deb    <= 1'b0;
         arr_db_cnt <= 8'd0;
         dep_db_cnt <= 8'd0;
         arr_deb_d  <= 1'b0;
         dep_deb_d  <= 1'b0;
      end else begin
         {arr_deb, arr_db_cnt} <= arr_db_nxt;
         {dep_deb, dep_db_cnt} <= dep_db_nxt;
         arr_deb_d             <= arr_deb;
         dep_deb_d             <= dep_deb;
      end
   end

   // Stage: rising-edge pulses; departures only count on yellow or green
   assign dep_ok = (cntry == 2'd1) || (cntry == 2'd2);
   assign arr_p0 = arr_deb & ~arr_deb_d;
   assign dep_p0 = dep_deb & ~dep_deb_d & dep_ok;

   always_comb begin
      {ovf_hit, cnt_nxt} = queue_step(queue_cnt, arr_p0, dep_p0);
   end

`ifdef STUCK_DETECT_EN
   localparam int SW = $clog2(STUCK_CYCLES + 1);
   localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_CYCLES - 1);

   logic [SW-1:0] stuck_cnt;
   logic          fault_set;

   assign fault_set = arr_deb && (stuck_cnt == STUCK_LAST);
   assign fault_nxt = sensor_fault | fault_set;

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         stuck_cnt    <= '0;
         sensor_fault <= 1'b0;
      end else begin
         sensor_fault <= fault_nxt;
         if (!arr_deb)
            stuck_cnt <= '0;
         else if (stuck_cnt != STUCK_LAST)
            stuck_cnt <= stuck_cnt + 1'b1;
      end
   end
`else
   assign fault_nxt    = 1'b0;
   assign sensor_fault = 1'b0;
`endif

   // Stage: queue register; x follows the next count so both move on one edge
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         queue_cnt <= '0;
         q_ovf     <= 1'b0;
         x         <= 1'b0;
      end else begin
         queue_cnt <= cnt_nxt;
         q_ovf     <= q_ovf | ovf_hit;
         x         <= (cnt_nxt != '0) | fault_nxt;
      end
   end

endmodule

// File: tb/tb_country_car_sensor.sv
// Scoreboard bench for country_car_sensor: stimulus pushes expected output changes, a monitor pops on every observed change.
module tb_country_car_sensor;

   localparam logic [1:0] RED = 2'd0, YELLOW = 2'd1, GREEN = 2'd2, ALT_RED = 2'd3;

   logic       clk = 1'b0;
   logic       clear = 1'b0;
   logic       car_arr_raw = 1'b0;
   logic       car_dep_raw = 1'b0;
   logic [1:0] cntry = 2'd0;
   logic       x;
   logic [3:0] queue_cnt;
   logic       q_ovf;
   logic       sensor_fault;

   country_car_sensor #(.DB_CYCLES(4), .CNT_W(4), .STUCK_CYCLES(32)) dut (
      .clk(clk), .clear(clear), .car_arr_raw(car_arr_raw), .car_dep_raw(car_dep_raw),
      .cntry(cntry), .x(x), .queue_cnt(queue_cnt), .q_ovf(q_ovf), .sensor_fault(sensor_fault)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cnt;
      bit x;
      bit ovf;
      bit fault;
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Expected state after the most recently issued stimulus
   int e_cnt = 0;
   bit e_x = 0, e_ovf = 0, e_fault = 0;

   // Monitor: any output change pops one expectation
   logic [6:0] last = 7'd0;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or posedge clear);
         #1;
         if ({queue_cnt, x, q_ovf, sensor_fault} != last) begin
            last = {queue_cnt, x, q_ovf, sensor_fault};
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change: cyc=%0d got cnt=%0d x=%0d ovf=%0d fault=%0d, no change required",
                        cyc, queue_cnt, x, q_ovf, sensor_fault);
            end else begin
               e = sb.pop_front();
               if (int'(queue_cnt) != e.cnt || x != e.x || q_ovf != e.ovf || sensor_fault != e.fault ||
                   (e.cyc >= 0 && cyc != e.cyc)) begin
                  errors++;
                  $display("FAIL output_change: got cnt=%0d x=%0d ovf=%0d fault=%0d at edge %0d, required cnt=%0d x=%0d ovf=%0d fault=%0d at edge %0d",
                           queue_cnt, x, q_ovf, sensor_fault, cyc, e.cnt, e.x, e.ovf, e.fault, e.cyc);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input int c, input bit ex, input bit eo, input bit ef);
      checks++;
      if (int'(queue_cnt) != c || x != ex || q_ovf != eo || sensor_fault != ef) begin
         errors++;
         $display("FAIL %s: got cnt=%0d x=%0d ovf=%0d fault=%0d, required cnt=%0d x=%0d ovf=%0d fault=%0d",
                  name, queue_cnt, x, q_ovf, sensor_fault, c, ex, eo, ef);
      end
   endtask

   // Raise the selected raw inputs for 'hold' cycles, then release and let the debouncers settle.
   task automatic pulse(input bit a, input bit d, input logic [1:0] light, input int hold,
                        input int ecnt, input bit eovf);
      int k;
      bit ex;
      @(negedge clk);
      cntry       = light;
      car_arr_raw = a;
      car_dep_raw = d;
      k  = cyc + 1;
      ex = (ecnt != 0) || e_fault;
      if (ecnt != e_cnt || eovf != e_ovf || ex != e_x)
         sb.push_back('{ecnt, ex, eovf, e_fault, k + 6});
      e_cnt = ecnt;
      e_ovf = eovf;
      e_x   = ex;
      repeat (hold) @(negedge clk);
      car_arr_raw = 1'b0;
      car_dep_raw = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   // Asynchronous clear asserted between clock edges, checked before the next edge.
   task automatic do_clear(input string name);
      @(negedge clk);
      #2;
      if (e_cnt != 0 || e_x || e_ovf || e_fault)
         sb.push_back('{0, 1'b0, 1'b0, 1'b0, -1});
      e_cnt = 0; e_x = 0; e_ovf = 0; e_fault = 0;
      clear = 1'b1;
      #1;
      chk(name, 0, 0, 0, 0);
      @(negedge clk);
      clear = 1'b0;
   endtask

   initial begin
      #1 clear = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_state", 0, 0, 0, 0);
      clear = 1'b0;
      repeat (2) @(negedge clk);

      // Held arrival: one increment exactly 6 edges after the raw rise
      pulse(1, 0, RED, 10, 1, 0);
      chk("held_arrival", 1, 1, 0, 0);
      do_clear("clear_after_held");

      // 3-cycle glitch is rejected
      pulse(1, 0, RED, 3, 0, 0);
      chk("glitch_ignored", 0, 0, 0, 0);

      // Departure qualification by light colour
      pulse(1, 0, RED, 8, 1, 0);
      pulse(1, 0, RED, 8, 2, 0);
      pulse(0, 1, RED, 8, 2, 0);
      chk("dep_on_red", 2, 1, 0, 0);
      pulse(0, 1, GREEN, 8, 1, 0);
      chk("dep_on_green", 1, 1, 0, 0);
      pulse(0, 1, GREEN, 8, 0, 0);
      pulse(1, 0, RED, 8, 1, 0);
      pulse(0, 1, ALT_RED, 8, 1, 0);
      chk("dep_on_code3", 1, 1, 0, 0);
      pulse(0, 1, YELLOW, 8, 0, 0);
      pulse(0, 1, GREEN, 8, 0, 0);
      chk("dep_at_zero", 0, 0, 0, 0);
      pulse(1, 1, GREEN, 8, 0, 0);
      chk("coincident_at_zero", 0, 0, 0, 0);

      // Saturation and overflow
      for (int i = 0; i < 16; i++)
         pulse(1, 0, RED, 8, (i < 15) ? i + 1 : 15, i == 15);
      chk("saturated", 15, 1, 1, 0);
      pulse(1, 1, GREEN, 8, 15, 1);
      chk("coincident_at_max", 15, 1, 1, 0);
      for (int i = 0; i < 12; i++)
         pulse(0, 1, GREEN, 8, 14 - i, 1);
      chk("drained_to_3", 3, 1, 1, 0);

      // Mid-cycle clear drops everything without an edge
      do_clear("async_clear");
      pulse(1, 0, RED, 8, 1, 0);
      chk("arrival_after_clear", 1, 1, 0, 0);

`ifdef STUCK_DETECT_EN
      begin
         int k;
         do_clear("clear_before_stuck");
         @(negedge clk);
         cntry       = RED;
         car_arr_raw = 1'b1;
         k = cyc + 1;
         sb.push_back('{1, 1'b1, 1'b0, 1'b0, k + 6});
         sb.push_back('{1, 1'b1, 1'b0, 1'b1, k + 37});
         repeat (50) @(negedge clk);
         cntry       = GREEN;
         car_dep_raw = 1'b1;
         k = cyc + 1;
         sb.push_back('{0, 1'b1, 1'b0, 1'b1, k + 6});
         repeat (8) @(negedge clk);
         car_dep_raw = 1'b0;
         repeat (10) @(negedge clk);
         chk("stuck_forces_x", 0, 1, 0, 1);
         car_arr_raw = 1'b0;
         repeat (10) @(negedge clk);
         chk("stuck_sticky", 0, 1, 0, 1);
         e_cnt = 0; e_x = 1; e_ovf = 0; e_fault = 1;
         do_clear("clear_stuck");
      end
`endif

      repeat (20) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL pending_expectations: %0d output changes never observed, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
